// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: FSM state encoding and framing sizes.
package uart_pkg;
    localparam int CLKS_PER_BIT_DEF = 104;
    localparam int DATA_BITS        = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;
endpackage

// File: rtl/sync_ff.sv
// Multi-stage single-bit synchroniser for an asynchronous input.
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ff <= {STAGES{RST_VAL}};
        else      ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised rx, mid-bit sampling, byte strobe and framing-error pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] uart_data,
    output logic                 uart_data_stb,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    logic                 rx_s;
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            uart_data     <= '0;
            uart_data_stb <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            uart_data_stb <= 1'b0;
            frame_err     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        cnt   <= '0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    // Re-check at mid start bit so short low glitches are dropped.
                    if (cnt == CNT_HALF) begin
                        if (!rx_s) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            state   <= S_DATA;
                        end else begin
                            state   <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt == CNT_LAST) begin
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        cnt   <= '0;
                        if (bit_idx == 3'd7) state <= S_STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    // Leaving at mid stop bit leaves half a bit to catch the next start edge.
                    if (cnt == CNT_LAST) begin
                        if (rx_s) begin
                            uart_data     <= shreg;
                            uart_data_stb <= 1'b1;
                            state         <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_BREAK: begin
                    if (rx_s) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx against a frame-level expectation queue.
module tb_uart_rx;
    localparam int CPB  = 16;
    localparam int SYNC = 2;
    localparam int LAT  = SYNC + CPB/2 + 9*CPB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] uart_data;
    logic       uart_data_stb, frame_err, busy;

    uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .uart_data     (uart_data),
        .uart_data_stb (uart_data_stb),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0, n_err = 0;
    int n_stb = 0, n_fe = 0, exp_fe = 0, n_exp = 0;
    logic [7:0] exp_q[$];
    int         fall_q[$];
    int         stb_t[$];
    logic [7:0] last_good = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Frame-level monitor: every strobe must match the oldest outstanding good frame.
    logic [7:0] m_e;
    int         m_f, m_lat;
    logic       prev_stb = 1'b0, prev_fe = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            if (uart_data_stb && frame_err) chk("stb_fe_excl", 1, 0);
            if (uart_data_stb && prev_stb)  chk("stb_width", 2, 1);
            if (frame_err && prev_fe)       chk("fe_width", 2, 1);
            if (uart_data_stb) begin
                n_stb++;
                if (stb_t.size() > 0 && cyc - stb_t[$] < 10*CPB - 1)
                    chk("stb_spacing", cyc - stb_t[$], 10*CPB - 1);
                stb_t.push_back(cyc);
                if (exp_q.size() == 0) chk("unexpected_stb", 1, 0);
                else begin
                    m_e = exp_q.pop_front();
                    m_f = fall_q.pop_front();
                    chk("data", uart_data, m_e);
                    m_lat = cyc - m_f;
                    chk("latency", (m_lat >= LAT-1 && m_lat <= LAT+1) ? LAT : m_lat, LAT);
                    last_good = m_e;
                end
            end
            if (frame_err) n_fe++;
        end
        prev_stb = uart_data_stb;
        prev_fe  = frame_err;
    end

    // Called at posedge+1; returns at posedge+1 just after the stop bit ends.
    task automatic send(input logic [7:0] b, input bit good_stop, input bit track);
        rx = 1'b0;
        if (track) begin
            exp_q.push_back(b);
            fall_q.push_back(cyc);
            n_exp++;
        end
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1 rx = b[i];
        end
        repeat (CPB) @(posedge clk);
        #1 rx = good_stop;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20*CPB && exp_q.size() != 0; i++) @(posedge clk);
        #1 chk("drain", exp_q.size(), 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int         s0;
    logic [7:0] rb;
    int         gap;

    initial begin
        idle(2);
        chk("rst_data", uart_data, 8'h00);
        chk("rst_stb", uart_data_stb, 0);
        chk("rst_fe", frame_err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        idle(4);

        // Single frame
        send(8'h41, 1, 1);
        drain();
        chk("single_cnt", n_stb, 1);
        idle(20);
        chk("single_hold", uart_data, 8'h41);
        chk("single_busy", busy, 0);
        chk("single_fe", n_fe, 0);

        // Back-to-back with no idle gap, then extremes
        s0 = stb_t.size();
        send(8'h0A, 1, 1);
        send(8'h55, 1, 1);
        drain();
        chk("b2b_cnt", stb_t.size() - s0, 2);
        gap = stb_t[$] - stb_t[$-1];
        chk("b2b_gap", (gap >= 159 && gap <= 161) ? 160 : gap, 160);
        send(8'h00, 1, 1);
        send(8'hFF, 1, 1);
        drain();
        chk("ext_hold", uart_data, 8'hFF);

        // Glitch rejection
        idle(5);
        s0 = n_stb;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(8);
        chk("glitch_busy", busy, 0);
        chk("glitch_stb", n_stb - s0, 0);
        chk("glitch_fe", n_fe, exp_fe);
        send(8'h33, 1, 1);
        drain();

        // Framing error followed by a held-low break
        idle(3);
        s0 = n_stb;
        send(8'hA5, 0, 0);
        exp_fe++;
        chk("ferr_cnt", n_fe, exp_fe);
        chk("ferr_hold", uart_data, last_good);
        chk("ferr_busy0", busy, 1);
        idle(40);
        chk("ferr_busy1", busy, 1);
        chk("ferr_once", n_fe, exp_fe);
        chk("ferr_nostb", n_stb - s0, 0);
        rx = 1'b1;
        idle(5);
        chk("ferr_idle", busy, 0);
        send(8'h12, 1, 1);
        drain();

        // Randomised frames with random gaps and occasional bad stop bits
        for (int k = 0; k < 10; k++) begin
            rb  = 8'($urandom);
            gap = $urandom_range(0, 2*CPB);
            if (gap > 0) idle(gap);
            if ($urandom_range(0, 4) == 0) begin
                send(rb, 0, 0);
                exp_fe++;
                idle($urandom_range(0, 30));
                rx = 1'b1;
                idle(4);
            end else begin
                send(rb, 1, 1);
            end
        end
        drain();
        chk("rand_fe", n_fe, exp_fe);

        // Reset asserted during bit 3 of 0x7E
        idle(3);
        s0 = n_stb;
        rb = 8'h7E;
        rx = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (CPB) @(posedge clk);
            #1 rx = rb[i];
        end
        idle(CPB/2);
        rst = 1'b0;
        rx  = 1'b1;
        #1;
        chk("mid_rst_data", uart_data, 8'h00);
        chk("mid_rst_stb", uart_data_stb, 0);
        chk("mid_rst_fe", frame_err, 0);
        chk("mid_rst_busy", busy, 0);
        last_good = 8'h00;
        idle(4);
        chk("mid_rst_busy2", busy, 0);
        rst = 1'b1;
        idle(3);
        chk("post_rst_nostb", n_stb - s0, 0);
        send(8'hC3, 1, 1);
        drain();
        chk("post_rst_cnt", n_stb - s0, 1);
        chk("post_rst_data", uart_data, 8'hC3);

        idle(10);
        chk("total_stb", n_stb, n_exp);
        chk("total_fe", n_fe, exp_fe);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, limit reached");
        $fatal(1);
    end
endmodule
